// File: rtl/rv32_regfile_wb.sv
// RV32I integer register file with writeback select and a multi-cycle load unit.
// Loads stall the core until data memory answers or the load times out.
module rv32_regfile_wb #(
  parameter int XLEN         = 32,
  parameter int NREG         = 32,
  parameter int LOAD_TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            instr_valid,
  input  logic [31:0]     idata,
  input  logic [XLEN-1:0] regdata_R,
  input  logic [XLEN-1:0] regdata_I,
  input  logic [XLEN-1:0] pc_plus4,
  input  logic [XLEN-1:0] imm_u_res,
  input  logic [1:0]      ld_addr_lo,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic [XLEN-1:0] rv1,
  output logic [XLEN-1:0] rv2,
  output logic            stall,
  output logic            load_err
);

  localparam int CW = $clog2(LOAD_TIMEOUT + 1);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;

  typedef enum logic {RUN, LOAD_WAIT} state_t;

  state_t          state, state_n;
  logic [XLEN-1:0] regs [NREG];
  logic [CW-1:0]   cnt, cnt_n;
  logic [4:0]      ld_rd;
  logic [2:0]      ld_f3;
  logic [1:0]      ld_lo;

  logic [4:0]      rs1, rs2, rd;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            unused_idata;

  logic            wr_en, wr_commit, latch, err_set, timeout_hit;
  logic [4:0]      wr_rd;
  logic [XLEN-1:0] wr_data, ld_ext;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic            ld_ok;

  assign rs1          = idata[19:15];
  assign rs2          = idata[24:20];
  assign rd           = idata[11:7];
  assign opcode       = idata[6:0];
  assign funct3       = idata[14:12];
  assign unused_idata = ^idata[31:25];

  assign timeout_hit = (cnt == CW'(LOAD_TIMEOUT - 1));

  // Lane extraction uses the offset latched with the load, not the live one.
  always_comb begin
    ld_byte = dmem_rdata[7:0];
    ld_half = ld_lo[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    ld_ext  = '0;
    ld_ok   = 1'b1;
    case (ld_lo)
      2'd1:    ld_byte = dmem_rdata[15:8];
      2'd2:    ld_byte = dmem_rdata[23:16];
      2'd3:    ld_byte = dmem_rdata[31:24];
      default: ld_byte = dmem_rdata[7:0];
    endcase
    case (ld_f3)
      3'b000:  ld_ext = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext = {{(XLEN-16){ld_half[15]}}, ld_half};
      3'b010:  ld_ext = dmem_rdata;
      3'b100:  ld_ext = {{(XLEN-8){1'b0}}, ld_byte};
      3'b101:  ld_ext = {{(XLEN-16){1'b0}}, ld_half};
      default: ld_ok  = 1'b0;
    endcase
  end

  // Next-state, writeback select and stall.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    wr_en   = 1'b0;
    wr_rd   = rd;
    wr_data = '0;
    stall   = 1'b0;
    latch   = 1'b0;
    err_set = 1'b0;
    case (state)
      RUN: begin
        if (instr_valid) begin
          case (opcode)
            OP_R: begin
              wr_en   = 1'b1;
              wr_data = regdata_R;
            end
            OP_I: begin
              wr_en   = 1'b1;
              wr_data = regdata_I;
            end
            OP_JAL, OP_JALR: begin
              wr_en   = 1'b1;
              wr_data = pc_plus4;
            end
            OP_LUI, OP_AUIPC: begin
              wr_en   = 1'b1;
              wr_data = imm_u_res;
            end
            OP_LOAD: begin
              stall   = 1'b1;
              latch   = 1'b1;
              cnt_n   = '0;
              state_n = LOAD_WAIT;
            end
            default: wr_en = 1'b0;
          endcase
        end
      end
      LOAD_WAIT: begin
        stall = 1'b1;
        cnt_n = cnt + 1'b1;
        wr_rd = ld_rd;
        if (dmem_rvalid) begin
          stall   = 1'b0;
          wr_en   = ld_ok;
          wr_data = ld_ext;
          state_n = RUN;
        end else if (timeout_hit) begin
          err_set = 1'b1;
          state_n = RUN;
        end
      end
      default: state_n = RUN;
    endcase
  end

  assign wr_commit = wr_en && (wr_rd != 5'd0) && !rst;

  // Read ports with bypass of the value committing at the coming edge.
  always_comb begin
    rv1 = '0;
    rv2 = '0;
    if (rs1 != 5'd0) rv1 = (wr_commit && wr_rd == rs1) ? wr_data : regs[rs1];
    if (rs2 != 5'd0) rv2 = (wr_commit && wr_rd == rs2) ? wr_data : regs[rs2];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      cnt      <= '0;
      ld_rd    <= '0;
      ld_f3    <= '0;
      ld_lo    <= '0;
      load_err <= 1'b0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (latch) begin
        ld_rd <= rd;
        ld_f3 <= funct3;
        ld_lo <= ld_addr_lo;
      end
      if (err_set) load_err <= 1'b1;
      if (wr_commit) regs[wr_rd] <= wr_data;
    end
  end

endmodule

// File: tb/tb_rv32_regfile_wb.sv
// Self-checking bench for rv32_regfile_wb: directed test-plan steps followed by
// random traffic, all compared against an architectural register-file model.
module tb_rv32_regfile_wb;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_SYS    = 7'b1110011;

  logic        clk = 1'b0;
  logic        rst, instr_valid, dmem_rvalid;
  logic [31:0] idata, regdata_R, regdata_I, pc_plus4, imm_u_res, dmem_rdata;
  logic [1:0]  ld_addr_lo;
  logic [31:0] rv1, rv2;
  logic        stall, load_err;

  rv32_regfile_wb dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .idata(idata),
    .regdata_R(regdata_R), .regdata_I(regdata_I), .pc_plus4(pc_plus4),
    .imm_u_res(imm_u_res), .ld_addr_lo(ld_addr_lo), .dmem_rvalid(dmem_rvalid),
    .dmem_rdata(dmem_rdata), .rv1(rv1), .rv2(rv2), .stall(stall), .load_err(load_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int stall_seen = 0;

  // Architectural model: register contents plus the pending-load bookkeeping.
  logic [31:0] m_regs [32];
  bit          m_loading;
  int          m_wait, m_rd, m_f3, m_lo;
  bit          m_err;

  function automatic logic [31:0] mkInstr(logic [6:0] op, int rd, int f3, int rs1, int rs2);
    return {7'b0, 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), op};
  endfunction

  function automatic logic [31:0] loadValue(int f3, int lo, logic [31:0] w, output bit ok);
    int b, h;
    b  = int'((w >> (lo * 8)) & 32'hFF);
    h  = int'((w >> ((lo / 2) * 16)) & 32'hFFFF);
    ok = 1'b1;
    case (f3)
      0:       return (b >= 128) ? 32'(b - 256) : 32'(b);
      1:       return (h >= 32768) ? 32'(h - 65536) : 32'(h);
      2:       return w;
      4:       return 32'(b);
      5:       return 32'(h);
      default: begin
        ok = 1'b0;
        return 32'h0;
      end
    endcase
  endfunction

  function automatic void modelWrite(output bit we, output int rd, output logic [31:0] val);
    bit ok;
    we  = 1'b0;
    rd  = 0;
    val = 32'h0;
    if (rst) return;
    if (!m_loading) begin
      if (!instr_valid) return;
      rd = int'(idata[11:7]);
      case (idata[6:0])
        OP_R:             begin we = 1'b1; val = regdata_R; end
        OP_I:             begin we = 1'b1; val = regdata_I; end
        OP_JAL, OP_JALR:  begin we = 1'b1; val = pc_plus4;  end
        OP_LUI, OP_AUIPC: begin we = 1'b1; val = imm_u_res; end
        default:          we = 1'b0;
      endcase
    end else if (dmem_rvalid) begin
      rd  = m_rd;
      val = loadValue(m_f3, m_lo, dmem_rdata, ok);
      we  = ok;
    end
    if (rd == 0) we = 1'b0;
  endfunction

  function automatic void checkVal(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endfunction

  task automatic checkOutput();
    bit          we;
    int          rd, s1, s2;
    logic [31:0] val, e1, e2;
    bit          es;
    modelWrite(we, rd, val);
    s1 = int'(idata[19:15]);
    s2 = int'(idata[24:20]);
    e1 = (s1 == 0) ? 32'h0 : ((we && rd == s1) ? val : m_regs[s1]);
    e2 = (s2 == 0) ? 32'h0 : ((we && rd == s2) ? val : m_regs[s2]);
    es = m_loading ? !dmem_rvalid : (instr_valid && idata[6:0] == OP_LOAD);
    if (stall === 1'b1) stall_seen++;
    checkVal("rv1", rv1, e1);
    checkVal("rv2", rv2, e2);
    checkVal("stall", {31'b0, stall}, {31'b0, es});
    checkVal("load_err", {31'b0, load_err}, {31'b0, m_err});
  endtask

  task automatic modelStep();
    bit          we;
    int          rd;
    logic [31:0] val;
    if (rst) begin
      foreach (m_regs[i]) m_regs[i] = 32'h0;
      m_loading = 1'b0;
      m_err     = 1'b0;
      return;
    end
    modelWrite(we, rd, val);
    if (we) m_regs[rd] = val;
    if (!m_loading) begin
      if (instr_valid && idata[6:0] == OP_LOAD) begin
        m_loading = 1'b1;
        m_wait    = 0;
        m_rd      = int'(idata[11:7]);
        m_f3      = int'(idata[14:12]);
        m_lo      = int'(ld_addr_lo);
      end
    end else begin
      m_wait++;
      if (dmem_rvalid) m_loading = 1'b0;
      else if (m_wait == 255) begin
        m_err     = 1'b1;
        m_loading = 1'b0;
      end
    end
  endtask

  task automatic toNegedge();
    @(negedge clk);
    checkOutput();
  endtask

  task automatic toPosedge();
    @(posedge clk);
    modelStep();
    #1;
  endtask

  task automatic applyStimulus();
    toNegedge();
    toPosedge();
  endtask

  task automatic randData();
    regdata_R = $urandom;
    regdata_I = $urandom;
    pc_plus4  = $urandom;
    imm_u_res = $urandom;
  endtask

  task automatic checkReg(int idx, logic [31:0] exp, string tag);
    instr_valid = 1'b0;
    dmem_rvalid = 1'b0;
    idata       = mkInstr(OP_R, 0, 0, idx, 0);
    toNegedge();
    checkVal(tag, rv1, exp);
    toPosedge();
  endtask

  // Wait cycles carry a valid R-type and a moving offset that must both be ignored.
  task automatic doLoad(int f3, int rd, int lo, logic [31:0] rdata, int waits, bit give_rvalid);
    randData();
    instr_valid = 1'b1;
    dmem_rvalid = 1'b0;
    ld_addr_lo  = 2'(lo);
    idata       = mkInstr(OP_LOAD, rd, f3, 1, 2);
    applyStimulus();
    for (int i = 0; i < waits; i++) begin
      randData();
      idata      = mkInstr(OP_R, rd, 0, rd, 3);
      ld_addr_lo = 2'($urandom);
      applyStimulus();
    end
    if (give_rvalid) begin
      dmem_rvalid = 1'b1;
      dmem_rdata  = rdata;
      applyStimulus();
    end
    instr_valid = 1'b0;
    dmem_rvalid = 1'b0;
  endtask

  task automatic writeR(int rd, logic [31:0] v);
    randData();
    regdata_R   = v;
    instr_valid = 1'b1;
    dmem_rvalid = 1'b0;
    idata       = mkInstr(OP_R, rd, 0, 0, 0);
    applyStimulus();
  endtask

  initial begin
    logic [6:0] ops [10];
    ops = '{OP_R, OP_I, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_LOAD, OP_STORE, OP_BRANCH, OP_SYS};
    rst = 1'b1; instr_valid = 1'b0; dmem_rvalid = 1'b0; idata = 32'h0;
    dmem_rdata = 32'h0; ld_addr_lo = 2'd0;
    randData();
    foreach (m_regs[i]) m_regs[i] = 32'h0;
    m_loading = 1'b0; m_err = 1'b0; m_wait = 0; m_rd = 0; m_f3 = 0; m_lo = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    checkReg(1, 32'h0, "reset_x1");
    checkReg(31, 32'h0, "reset_x31");

    writeR(5, 32'h0000_00AA);
    checkReg(5, 32'h0000_00AA, "r_commit_x5");

    randData();
    regdata_R   = 32'h1234_5678;
    instr_valid = 1'b1;
    idata       = mkInstr(OP_R, 6, 0, 6, 5);
    toNegedge();
    checkVal("bypass_rv1", rv1, 32'h1234_5678);
    toPosedge();

    writeR(0, 32'hDEAD_BEEF);
    checkReg(0, 32'h0, "x0_guard");

    stall_seen = 0;
    doLoad(0, 7, 2, 32'h1280_3456, 3, 1'b1);
    checkVal("lb_stall_cycles", 32'(stall_seen), 32'd4);
    checkReg(7, 32'hFFFF_FF80, "lb_sign");
    doLoad(4, 7, 2, 32'h1280_3456, 3, 1'b1);
    checkReg(7, 32'h0000_0080, "lbu_zero");
    doLoad(1, 8, 2, 32'h8001_1234, 1, 1'b1);
    checkReg(8, 32'hFFFF_8001, "lh_sign");
    stall_seen = 0;
    doLoad(2, 9, 0, 32'hCAFE_F00D, 0, 1'b1);
    checkVal("lw_min_stall", 32'(stall_seen), 32'd1);
    checkReg(9, 32'hCAFE_F00D, "lw_word");
    doLoad(3, 9, 1, 32'h1111_2222, 2, 1'b1);
    checkReg(9, 32'hCAFE_F00D, "reserved_f3_nowrite");

    writeR(10, 32'h0000_0055);
    doLoad(2, 10, 0, 32'h0, 255, 1'b0);
    toNegedge();
    checkVal("timeout_err", {31'b0, load_err}, 32'd1);
    checkVal("timeout_stall", {31'b0, stall}, 32'd0);
    toPosedge();
    checkReg(10, 32'h0000_0055, "timeout_rd_kept");

    doLoad(2, 11, 0, 32'h0, 2, 1'b0);
    rst         = 1'b1;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h7777_7777;
    applyStimulus();
    rst         = 1'b0;
    dmem_rvalid = 1'b0;
    toNegedge();
    checkVal("rst_mid_stall", {31'b0, stall}, 32'd0);
    checkVal("rst_mid_err", {31'b0, load_err}, 32'd0);
    toPosedge();
    for (int i = 0; i < 32; i++) checkReg(i, 32'h0, "rst_mid_regs");

    doLoad(2, 12, 0, 32'hA5A5_0F0F, 254, 1'b1);
    checkReg(12, 32'hA5A5_0F0F, "rvalid_on_timeout");
    checkVal("rvalid_on_timeout_err", {31'b0, load_err}, 32'd0);

    for (int n = 0; n < 400; n++) begin
      randData();
      idata       = $urandom;
      idata[6:0]  = ops[$urandom_range(0, 9)];
      instr_valid = ($urandom_range(0, 9) < 8);
      ld_addr_lo  = 2'($urandom);
      dmem_rdata  = $urandom;
      dmem_rvalid = m_loading && ($urandom_range(0, 9) < 3);
      applyStimulus();
    end
    dmem_rvalid = 1'b1;
    instr_valid = 1'b0;
    applyStimulus();
    for (int i = 0; i < 32; i++) checkReg(i, m_regs[i], "final_regs");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
